// File: rtl/dyn_reconf_ctrl.sv
// DRP reprogramming sequencer: holds the PLL in reset, walks a table of (addr, mask, data)
// entries doing a read-modify-write per entry, then releases reset and waits for lock.
module dyn_reconf_ctrl #(
    parameter int NUM_ENTRIES  = 23,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        dclk_i,
    input  logic        rst_n_i,
    input  logic        sstart_i,
    output logic        srdy_o,
    output logic        sdone_o,
    output logic        serr_o,
    output logic [6:0]  tbl_idx_o,
    input  logic [38:0] tbl_data_i,
    output logic [6:0]  daddr_o,
    output logic        den_o,
    output logic        dwe_o,
    output logic [15:0] di_o,
    input  logic [15:0] do_i,
    input  logic        drdy_i,
    input  logic        locked_i,
    output logic        pll_rst_o
);

    localparam int DTW = $clog2(DRDY_TIMEOUT) + 1;
    localparam int LTW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [DTW-1:0] DRDY_TC  = DTW'(DRDY_TIMEOUT - 1);
    localparam logic [LTW-1:0] LOCK_TC  = LTW'(LOCK_TIMEOUT - 1);
    localparam logic [6:0]     LAST_IDX = 7'(NUM_ENTRIES - 1);

    // state | meaning: IDLE ready | ASSERT_RST PLL into reset | RD/WR DRP strobe cycle |
    // RD_WAIT/WR_WAIT await DRDY | RELEASE drop PLL reset | LOCK_WAIT await LOCKED
    typedef enum logic [2:0] {
        IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT
    } state_t;

    state_t             state_q;
    logic               srdy_q, sdone_q, serr_q, den_q, dwe_q, pll_rst_q;
    logic [6:0]         tbl_idx_q, daddr_q;
    logic [15:0]        di_q, di_d;
    logic [DTW-1:0]     drdy_tmr_q;
    logic [LTW-1:0]     lock_tmr_q;
    logic [6:0]         tbl_addr;
    logic [15:0]        tbl_mask, tbl_wdata;

    assign tbl_addr  = tbl_data_i[38:32];
    assign tbl_mask  = tbl_data_i[31:16];
    assign tbl_wdata = tbl_data_i[15:0];

    // Mask bit set keeps the bit read back from the PLL.
    assign di_d = (do_i & tbl_mask) | (tbl_wdata & ~tbl_mask);

    always_ff @(posedge dclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            srdy_q     <= 1'b1;
            sdone_q    <= 1'b0;
            serr_q     <= 1'b0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            pll_rst_q  <= 1'b0;
            tbl_idx_q  <= '0;
            daddr_q    <= '0;
            di_q       <= '0;
            drdy_tmr_q <= '0;
            lock_tmr_q <= '0;
        end else begin
            sdone_q <= 1'b0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sstart_i) begin
                        srdy_q    <= 1'b0;
                        serr_q    <= 1'b0;
                        tbl_idx_q <= '0;
                        pll_rst_q <= 1'b1;
                        state_q   <= ASSERT_RST;
                    end
                end
                ASSERT_RST: begin
                    den_q   <= 1'b1;
                    state_q <= RD;
                end
                RD: begin
                    daddr_q    <= tbl_addr;
                    drdy_tmr_q <= '0;
                    state_q    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (drdy_i) begin
                        di_q    <= di_d;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= WR;
                    end else if (drdy_tmr_q == DRDY_TC) begin
                        serr_q  <= 1'b1;
                        state_q <= RELEASE;
                    end else if (drdy_tmr_q != '1) begin
                        drdy_tmr_q <= drdy_tmr_q + 1'b1;
                    end
                end
                WR: begin
                    drdy_tmr_q <= '0;
                    state_q    <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (drdy_i) begin
                        if (tbl_idx_q == LAST_IDX) begin
                            state_q <= RELEASE;
                        end else begin
                            tbl_idx_q <= tbl_idx_q + 7'd1;
                            den_q     <= 1'b1;
                            state_q   <= RD;
                        end
                    end else if (drdy_tmr_q == DRDY_TC) begin
                        serr_q  <= 1'b1;
                        state_q <= RELEASE;
                    end else if (drdy_tmr_q != '1) begin
                        drdy_tmr_q <= drdy_tmr_q + 1'b1;
                    end
                end
                RELEASE: begin
                    pll_rst_q  <= 1'b0;
                    lock_tmr_q <= '0;
                    state_q    <= LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    if (locked_i) begin
                        sdone_q <= 1'b1;
                        srdy_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (lock_tmr_q == LOCK_TC) begin
                        serr_q  <= 1'b1;
                        sdone_q <= 1'b1;
                        srdy_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (lock_tmr_q != '1) begin
                        lock_tmr_q <= lock_tmr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The table lookup follows tbl_idx_o combinationally, so the address for the read strobe
    // is taken straight from the table and held in daddr_q for the rest of the entry.
    assign daddr_o   = (state_q == RD) ? tbl_addr : daddr_q;
    assign srdy_o    = srdy_q;
    assign sdone_o   = sdone_q;
    assign serr_o    = serr_q;
    assign den_o     = den_q;
    assign dwe_o     = dwe_q;
    assign di_o      = di_q;
    assign tbl_idx_o = tbl_idx_q;
    assign pll_rst_o = pll_rst_q;

endmodule
